// File: rtl/scratch_pad_loader_pkg.sv
// scratch_pad_loader_pkg: shared FSM state encoding, step codes and sizing helpers
package scratch_pad_loader_pkg;
  localparam logic [1:0] S_IDLE = 2'd0, S_ACT = 2'd1, S_WGT = 2'd2, S_FIN = 2'd3;
  localparam logic [2:0] STEP_IDLE = 3'd0, STEP_ACT_WR = 3'd1, STEP_WGT_WR = 3'd2,
                         STEP_WAIT = 3'd3, STEP_FIN = 3'd4;
  function automatic int unsigned idx_w(input int unsigned n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic logic [2:0] clamp_layers(input logic [2:0] n, input int unsigned max);
    return (32'(n) > max) ? 3'(max) : n;
  endfunction
endpackage

// File: rtl/scratch_pad_loader_load_index_counter.sv
// load_index_counter: addr/bank/layer cascade with terminal flag at the last word of the last layer
module load_index_counter #(
  parameter int BANKS = 1,
  parameter int BANK_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [2:0]        last_layer,
  output logic              addr,
  output logic [BANK_W-1:0] bank,
  output logic [2:0]        layer,
  output logic              last
);
  logic bank_max;
  assign bank_max = bank == BANK_W'(BANKS - 1);
  assign last = addr && bank_max && layer == last_layer;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr  <= 1'b0;
      bank  <= '0;
      layer <= '0;
    end else if (clr || (inc && last)) begin
      addr  <= 1'b0;
      bank  <= '0;
      layer <= '0;
    end else if (inc) begin
      addr <= !addr;
      if (addr) begin
        bank <= bank_max ? '0 : bank + 1'b1;
        if (bank_max) layer <= layer + 3'd1;
      end
    end
endmodule

// File: rtl/scratch_pad_loader.sv
// scratch_pad_loader: streams activations then weights into scratch-pad banks,
// emitting a registered write strobe one cycle after each accepted beat
module scratch_pad_loader
  import scratch_pad_loader_pkg::*;
#(
  parameter int BUFFER_SIZE = 5,
  parameter int SYS_WIDTH   = 64,
  parameter int SYS_HEIGHT  = 1,
  localparam int AW = idx_w(SYS_HEIGHT),
  localparam int WW = idx_w(SYS_WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    num_layers,
  input  logic [31:0]   data_in,
  input  logic          data_in_valid,
  output logic          data_in_ready,
  output logic [2:0]    step,
  output logic [31:0]   data_received,
  output logic [AW-1:0] act_bram_num,
  output logic          act_bram_addr,
  output logic [2:0]    act_bram_layer,
  output logic [WW-1:0] weight_bram_num,
  output logic          weight_bram_addr,
  output logic [2:0]    weight_bram_layer,
  output logic          done
);
  logic [1:0] state, nxt;
  logic [2:0] last_layer, act_layer, wgt_layer;
  logic [AW-1:0] act_bank;
  logic [WW-1:0] wgt_bank;
  logic beat, clr, act_addr, wgt_addr, act_last, wgt_last;
  assign beat = data_in_valid && data_in_ready && !abort;
  assign clr  = abort || (state == S_IDLE && start);
  always_comb
    nxt = abort ? S_IDLE
        : state == S_IDLE ? (start ? (num_layers == 3'd0 ? S_FIN : S_ACT) : S_IDLE)
        : state == S_ACT  ? (beat && act_last ? S_WGT : S_ACT)
        : state == S_WGT  ? (beat && wgt_last ? S_FIN : S_WGT)
        : S_IDLE;
  load_index_counter #(.BANKS(SYS_HEIGHT), .BANK_W(AW)) u_act (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(beat && state == S_ACT), .last_layer(last_layer),
    .addr(act_addr), .bank(act_bank), .layer(act_layer), .last(act_last)
  );
  load_index_counter #(.BANKS(SYS_WIDTH), .BANK_W(WW)) u_wgt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(beat && state == S_WGT), .last_layer(last_layer),
    .addr(wgt_addr), .bank(wgt_bank), .layer(wgt_layer), .last(wgt_last)
  );
  // outputs describe the previous cycle, so step reflects the state the beat happened in
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state             <= S_IDLE;
      last_layer        <= '0;
      data_in_ready     <= 1'b0;
      done              <= 1'b0;
      step              <= STEP_IDLE;
      data_received     <= '0;
      act_bram_num      <= '0;
      act_bram_addr     <= 1'b0;
      act_bram_layer    <= '0;
      weight_bram_num   <= '0;
      weight_bram_addr  <= 1'b0;
      weight_bram_layer <= '0;
    end else begin
      state         <= nxt;
      data_in_ready <= nxt == S_ACT || nxt == S_WGT;
      done          <= !abort && state == S_FIN;
      step <= abort ? STEP_IDLE
            : beat ? (state == S_ACT ? STEP_ACT_WR : STEP_WGT_WR)
            : state == S_FIN ? STEP_FIN
            : state == S_IDLE ? STEP_IDLE : STEP_WAIT;
      if (state == S_IDLE && start && !abort)
        last_layer <= clamp_layers(num_layers, BUFFER_SIZE) - 3'd1;
      if (beat) data_received <= data_in;
      if (beat && state == S_ACT) begin
        act_bram_num   <= act_bank;
        act_bram_addr  <= act_addr;
        act_bram_layer <= act_layer;
      end
      if (beat && state == S_WGT) begin
        weight_bram_num   <= wgt_bank;
        weight_bram_addr  <= wgt_addr;
        weight_bram_layer <= wgt_layer;
      end
    end
endmodule

// File: doc/scratch_pad_loader.md
SCRATCH_PAD_LOADER -- requirements
Module: scratch_pad_loader

Interface
REQ-001 Parameters SHALL be: BUFFER_SIZE, default 5, maximum number of layers; SYS_WIDTH, default 64, weight bank count; SYS_HEIGHT, default 1, activation bank count.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle load request, accepted only in IDLE.
REQ-005 abort  in  1  synchronous return to IDLE.
REQ-006 num_layers  in  3  layer count, sampled when start is accepted.
REQ-007 data_in  in  32  incoming stream word.
REQ-008 data_in_valid  in  1  data_in holds a valid word.
REQ-009 data_in_ready  out  1  loader accepts a word this cycle.
REQ-010 step  out  3  phase and write strobe for the scratch pad.
REQ-011 data_received  out  32  registered word to be written.
REQ-012 act_bram_num  out  1  activation bank index.
REQ-013 act_bram_addr  out  1  activation word address within a layer.
REQ-014 act_bram_layer  out  3  activation layer index.
REQ-015 weight_bram_num  out  6  weight bank index.
REQ-016 weight_bram_addr  out  1  weight word address within a layer.
REQ-017 weight_bram_layer  out  3  weight layer index.
REQ-018 done  out  1  one-cycle pulse when loading completes.

Function
REQ-019 The FSM SHALL have states IDLE, ACT, WGT and FIN.
- Transitions: IDLE->ACT on start; ACT->WGT after the last activation beat; WGT->FIN after the last weight beat; FIN->IDLE after one cycle.
REQ-020 A beat SHALL be a cycle with data_in_valid && data_in_ready.
- data_in_ready SHALL be 1 only in ACT and WGT.
REQ-021 Beat ordering in ACT SHALL be: layer outermost, bank middle, addr innermost.
- Beat count: L*SYS_HEIGHT*2.
REQ-022 Beat ordering in WGT SHALL be the same: layer outermost, bank middle, addr innermost.
- Beat count: L*SYS_WIDTH*2.
REQ-023 Every output SHALL be registered.
- In the cycle after each beat: data_received = the word; index outputs = that beat's indices; step = 1 for an ACT beat, 2 for a WGT beat.
REQ-024 step SHALL be 0 in IDLE, 3 in ACT/WGT cycles not following a beat, and 4 in FIN.
- Values 1 and 2 SHALL occur only as write strobes (one per beat).
REQ-025 Index outputs and data_received SHALL hold their last value when no beat occurs.
REQ-026 The effective layer count L SHALL be derived from num_layers at start:
- num_layers > BUFFER_SIZE: clamp to BUFFER_SIZE.
- num_layers == 0: go IDLE->FIN directly; no beats, done still pulses.
REQ-027 Counter wrap: addr 1->0 increments bank; bank max->0 increments layer; layer L-1 with bank and addr at max ends the phase.
- WGT counters SHALL start at 0.
REQ-028 done SHALL be 1 for exactly the cycle in which step = 4.
REQ-029 abort SHALL take priority over start and over a simultaneous beat.
- The beat is not accepted; next cycle step = 0, state IDLE, counters cleared.
REQ-030 start outside IDLE SHALL be ignored.
- start together with abort in IDLE SHALL be ignored.
REQ-031 Load latency SHALL be one cycle from beat to write strobe.
- Back-to-back beats SHALL give back-to-back strobes with no bubbles.

Reset
REQ-032 While rst_n = 0, the block SHALL set: state IDLE; step 0; data_received 0; all index outputs 0; data_in_ready 0; done 0; counters 0.
REQ-033 Reset mid-load SHALL discard the transfer; after release the block waits for a new start.

Structure
REQ-034 A shared package SHALL hold the state encoding and the step codes (IDLE 0, ACT_WR 1, WGT_WR 2, WAIT 3, FIN 4).
REQ-035 One sub-module, load_index_counter (addr/bank/layer cascade with terminal flag, bank width parameterised), SHALL be instantiated twice, once for ACT and once for WGT.

Verification
REQ-036 num_layers=1, valid held high, data_in = beat number -> 130 strobes.
- Strobes: 2 with step=1, then 128 with step=2.
- Last strobe: weight_bram_num=63, addr=1, data_received=129.
- done in the cycle after the last strobe.
REQ-037 num_layers=5, valid toggling every other cycle -> 650 beats.
- step=3 in gap cycles.
- Last ACT strobe: act_bram_layer=4, addr=1.
REQ-038 num_layers=7 -> clamped to 5; exactly 650 beats accepted, then data_in_ready=0.
REQ-039 num_layers=0 -> step 0,4,0; done pulses once; data_in_ready never asserted.
REQ-040 abort asserted on WGT beat 10 together with valid -> that word is not strobed.
- Next cycle: step=0.
- A new start restarts at act layer 0.
REQ-041 rst_n low for 1 cycle mid-ACT -> outputs 0 immediately; no strobe until a new start.
